butterfly_dif_inv: RTL and testbench

Pipelined radix-2 decimation-in-frequency butterfly for the inverse-FFT path: C = (A + B)/2, D = ((A − B)·W)/2, with per-stage 1/2 scaling so that a log2(N)-stage IFFT yields the 1/N normalisation. It consumes the same packed 32-bit complex format as the forward butterfly: real in [31:16], imag in [15:0], both signed Q1.15. It sits between the IFFT stage RAM reader and writer. A valid/ready handshake on both sides lets the stage controller stall it.

---
 rtl/butterfly_dif_inv_pkg.sv | 60 ++++++
 rtl/butterfly_dif_inv_if.sv | 25 ++
 rtl/butterfly_dif_inv_cmul_q15.sv | 72 +++++++
 rtl/butterfly_dif_inv.sv | 95 +++++++++
 tb/tb_butterfly_dif_inv.sv | 297 +++++++++++++++++++++++++++++
 5 files changed

// File: rtl/butterfly_dif_inv_pkg.sv
// Shared Q1.15 fixed-point definitions: widths, packed-complex field layout,
// and the rounding / saturation helpers used by the forward and inverse butterflies.
package butterfly_dif_inv_pkg;

    localparam int Q15_W  = 16;
    localparam int CPLX_W = 32;
    localparam int RE_MSB = 31;
    localparam int RE_LSB = 16;
    localparam int IM_MSB = 15;
    localparam int IM_LSB = 0;
    localparam int SUM_W  = Q15_W + 1;
    localparam int PROD_W = SUM_W + Q15_W;
    localparam int ACC_W  = PROD_W + 1;
    localparam int RND_W  = ACC_W - 16;

    localparam logic signed [SUM_W-1:0] SUM_ONE  = 17'sd1;
    localparam logic signed [ACC_W-1:0] RND_HALF = 34'sd32768;
    localparam logic signed [RND_W-1:0] Q15_MAX_X = 18'sd32767;
    localparam logic signed [RND_W-1:0] Q15_MIN_X = -18'sd32768;

    typedef logic signed [Q15_W-1:0] q15_t;
    typedef logic [CPLX_W-1:0]       cplx_t;

    function automatic q15_t cplx_re(input cplx_t x);
        return x[RE_MSB:RE_LSB];
    endfunction

    function automatic q15_t cplx_im(input cplx_t x);
        return x[IM_MSB:IM_LSB];
    endfunction

    function automatic cplx_t cplx_pack(input q15_t re, input q15_t im);
        return {re, im};
    endfunction

    // Negation of -1.0 has no Q1.15 representation; clamp it to +max.
    function automatic q15_t neg_sat(input q15_t x);
        return (x == 16'sh8000) ? 16'sh7fff : -x;
    endfunction

    function automatic q15_t half_round(input logic signed [SUM_W-1:0] s);
        return Q15_W'((s + SUM_ONE) >>> 1);
    endfunction

    // Q3.30 product sum to Q1.15 with an extra /2, round-half-up.
    function automatic logic signed [RND_W-1:0] round_q30(input logic signed [ACC_W-1:0] p);
        return RND_W'((p + RND_HALF) >>> 16);
    endfunction

    function automatic logic sat_hit(input logic signed [RND_W-1:0] x);
        return (x > Q15_MAX_X) || (x < Q15_MIN_X);
    endfunction

    function automatic q15_t sat_q15(input logic signed [RND_W-1:0] x);
        if (sat_hit(x))
            return x[RND_W-1] ? 16'sh8000 : 16'sh7fff;
        return x[Q15_W-1:0];
    endfunction

endpackage

// File: rtl/butterfly_dif_inv_if.sv
// Beat-level bundle between the IFFT stage RAM reader/writer and the butterfly.
interface butterfly_dif_inv_if;
    import butterfly_dif_inv_pkg::*;

    logic  i_valid;
    logic  o_ready;
    cplx_t i_A;
    cplx_t i_B;
    cplx_t i_twiddle;
    logic  o_valid;
    logic  i_ready;
    cplx_t o_C;
    cplx_t o_D;
    logic  o_sat;

    modport master (
        output i_valid, i_A, i_B, i_twiddle, i_ready,
        input  o_ready, o_valid, o_C, o_D, o_sat
    );

    modport slave (
        input  i_valid, i_A, i_B, i_twiddle, i_ready,
        output o_ready, o_valid, o_C, o_D, o_sat
    );
endinterface

// File: rtl/butterfly_dif_inv_cmul_q15.sv
// Complex multiply (17-bit diff x Q1.15 twiddle) with /2 scale, round and saturate.
// Latency 2 cycles; advances only when i_en is high so the caller owns backpressure.
module cmul_q15
    import butterfly_dif_inv_pkg::*;
(
    input  logic                    i_clk,
    input  logic                    i_rst,
    input  logic                    i_en,
    input  logic                    i_valid,
    input  logic signed [SUM_W-1:0] i_dr,
    input  logic signed [SUM_W-1:0] i_di,
    input  q15_t                    i_wr,
    input  q15_t                    i_wi,
    output logic                    o_valid,
    output q15_t                    o_re,
    output q15_t                    o_im,
    output logic                    o_sat
);

    logic signed [PROD_W-1:0] w_dr, w_di, w_wr, w_wi;
    logic signed [PROD_W-1:0] r_rr, r_ii, r_ri, r_ir;
    logic signed [ACC_W-1:0]  w_pr, w_pi;
    logic signed [RND_W-1:0]  w_pr_rnd, w_pi_rnd;
    logic                     r_v2, r_v3, r_sat;
    q15_t                     r_re, r_im;

    assign w_dr = PROD_W'(i_dr);
    assign w_di = PROD_W'(i_di);
    assign w_wr = PROD_W'(i_wr);
    assign w_wi = PROD_W'(i_wi);

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_v2 <= 1'b0;
            r_rr <= '0;
            r_ii <= '0;
            r_ri <= '0;
            r_ir <= '0;
        end else if (i_en) begin
            r_v2 <= i_valid;
            r_rr <= w_dr * w_wr;
            r_ii <= w_di * w_wi;
            r_ri <= w_dr * w_wi;
            r_ir <= w_di * w_wr;
        end
    end

    assign w_pr     = ACC_W'(r_rr) - ACC_W'(r_ii);
    assign w_pi     = ACC_W'(r_ri) + ACC_W'(r_ir);
    assign w_pr_rnd = round_q30(w_pr);
    assign w_pi_rnd = round_q30(w_pi);

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_v3  <= 1'b0;
            r_re  <= '0;
            r_im  <= '0;
            r_sat <= 1'b0;
        end else if (i_en) begin
            r_v3  <= r_v2;
            r_re  <= sat_q15(w_pr_rnd);
            r_im  <= sat_q15(w_pi_rnd);
            r_sat <= sat_hit(w_pr_rnd) | sat_hit(w_pi_rnd);
        end
    end

    assign o_valid = r_v3;
    assign o_re    = r_re;
    assign o_im    = r_im;
    assign o_sat   = r_sat;

endmodule

// File: rtl/butterfly_dif_inv.sv
// Inverse-FFT DIF butterfly: C=(A+B)/2, D=((A-B)*W)/2, Q1.15 packed complex.
// Latency 3 cycles, 1 beat/cycle; whole pipe freezes when the output is held and i_ready is low.
module butterfly_dif_inv
    import butterfly_dif_inv_pkg::*;
#(
    parameter bit CONJ_TWIDDLE = 1'b1,
    parameter int PIPE_LAT     = 3
) (
    input  logic                 i_clk,
    input  logic                 i_rst,
    butterfly_dif_inv_if.slave   bus
);

    if (PIPE_LAT != 3) begin : g_lat_chk
        $error("butterfly_dif_inv: PIPE_LAT must be 3");
    end

    logic                    w_en;
    logic                    w_v3;
    logic signed [SUM_W-1:0] w_a_re, w_a_im, w_b_re, w_b_im;
    q15_t                    w_tw_im;
    q15_t                    w_d_re, w_d_im;
    logic                    w_d_sat;

    logic                    r_v1;
    logic signed [SUM_W-1:0] r_sr, r_si, r_dr, r_di;
    q15_t                    r_wr, r_wi;
    q15_t                    r_cr2, r_ci2, r_cr3, r_ci3;

    // One enable for every stage: a bubble at the output is always reclaimable.
    assign w_en        = !w_v3 || bus.i_ready;
    assign bus.o_ready = w_en;

    assign w_a_re  = SUM_W'(cplx_re(bus.i_A));
    assign w_a_im  = SUM_W'(cplx_im(bus.i_A));
    assign w_b_re  = SUM_W'(cplx_re(bus.i_B));
    assign w_b_im  = SUM_W'(cplx_im(bus.i_B));
    assign w_tw_im = CONJ_TWIDDLE ? neg_sat(cplx_im(bus.i_twiddle)) : cplx_im(bus.i_twiddle);

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_v1 <= 1'b0;
            r_sr <= '0;
            r_si <= '0;
            r_dr <= '0;
            r_di <= '0;
            r_wr <= '0;
            r_wi <= '0;
        end else if (w_en) begin
            r_v1 <= bus.i_valid;
            r_sr <= w_a_re + w_b_re;
            r_si <= w_a_im + w_b_im;
            r_dr <= w_a_re - w_b_re;
            r_di <= w_a_im - w_b_im;
            r_wr <= cplx_re(bus.i_twiddle);
            r_wi <= w_tw_im;
        end
    end

    // C is ready after S2; the extra register keeps it aligned with D.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_cr2 <= '0;
            r_ci2 <= '0;
            r_cr3 <= '0;
            r_ci3 <= '0;
        end else if (w_en) begin
            r_cr2 <= half_round(r_sr);
            r_ci2 <= half_round(r_si);
            r_cr3 <= r_cr2;
            r_ci3 <= r_ci2;
        end
    end

    cmul_q15 u_cmul (
        .i_clk   (i_clk),
        .i_rst   (i_rst),
        .i_en    (w_en),
        .i_valid (r_v1),
        .i_dr    (r_dr),
        .i_di    (r_di),
        .i_wr    (r_wr),
        .i_wi    (r_wi),
        .o_valid (w_v3),
        .o_re    (w_d_re),
        .o_im    (w_d_im),
        .o_sat   (w_d_sat)
    );

    assign bus.o_valid = w_v3;
    assign bus.o_C     = cplx_pack(r_cr3, r_ci3);
    assign bus.o_D     = cplx_pack(w_d_re, w_d_im);
    assign bus.o_sat   = w_d_sat;

endmodule

// File: tb/tb_butterfly_dif_inv.sv
// Bench: two lockstep DUTs (CONJ_TWIDDLE=0/1) against an arithmetic reference model and scoreboard.
module tb_butterfly_dif_inv;
    import butterfly_dif_inv_pkg::*;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    butterfly_dif_inv_if bus0();
    butterfly_dif_inv_if bus1();

    assign bus1.i_valid   = bus0.i_valid;
    assign bus1.i_A       = bus0.i_A;
    assign bus1.i_B       = bus0.i_B;
    assign bus1.i_twiddle = bus0.i_twiddle;
    assign bus1.i_ready   = bus0.i_ready;

    butterfly_dif_inv #(.CONJ_TWIDDLE(1'b0), .PIPE_LAT(3)) dut0 (
        .i_clk (clk),
        .i_rst (rst),
        .bus   (bus0.slave)
    );

    butterfly_dif_inv #(.CONJ_TWIDDLE(1'b1), .PIPE_LAT(3)) dut1 (
        .i_clk (clk),
        .i_rst (rst),
        .bus   (bus1.slave)
    );

    typedef struct {
        logic [31:0] c;
        logic [31:0] d0;
        logic        s0;
        logic [31:0] d1;
        logic        s1;
    } exp_t;

    exp_t sb_q[$];
    int   n_chk = 0;
    int   n_fail = 0;
    int   cyc = 0;
    int   out_cnt = 0;
    int   last_out_cyc = 0;
    int   rdy_mode = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic longint clamp(input longint v);
        if (v > 32767) return 32767;
        if (v < -32768) return -32768;
        return v;
    endfunction

    function automatic void cmul_ref(input longint dr, di, wr, wi,
                                     output logic [31:0] d, output logic s);
        longint pr, pi, qr, qi;
        pr = dr * wr - di * wi;
        pi = dr * wi + di * wr;
        qr = (pr + 32768) >>> 16;
        qi = (pi + 32768) >>> 16;
        s  = (qr != clamp(qr)) || (qi != clamp(qi));
        d  = {16'(clamp(qr)), 16'(clamp(qi))};
    endfunction

    function automatic exp_t model(input logic [31:0] a, b, w);
        exp_t   m;
        longint ar, ai, br, bi, wr, wi, wic;
        ar = longint'($signed(a[31:16]));
        ai = longint'($signed(a[15:0]));
        br = longint'($signed(b[31:16]));
        bi = longint'($signed(b[15:0]));
        wr = longint'($signed(w[31:16]));
        wi = longint'($signed(w[15:0]));
        wic = (wi == -32768) ? 32767 : -wi;
        m.c = {16'((ar + br + 1) >>> 1), 16'((ai + bi + 1) >>> 1)};
        cmul_ref(ar - br, ai - bi, wr, wi,  m.d0, m.s0);
        cmul_ref(ar - br, ai - bi, wr, wic, m.d1, m.s1);
        return m;
    endfunction

    function automatic logic [15:0] rnd16();
        case ($urandom_range(0, 7))
            0:       return 16'h7FFF;
            1:       return 16'h8000;
            default: return 16'($urandom);
        endcase
    endfunction

    function automatic logic [31:0] rnd32();
        return {rnd16(), rnd16()};
    endfunction

    // Downstream ready: 0 = always ready, 1 = random, 2 = stalled.
    initial forever begin
        case (rdy_mode)
            1:       bus0.i_ready = 1'($urandom_range(0, 1));
            2:       bus0.i_ready = 1'b0;
            default: bus0.i_ready = 1'b1;
        endcase
        @(posedge clk);
        #2;
    end

    // Scoreboard: every cycle with o_valid must show the oldest outstanding beat.
    always @(negedge clk) begin
        exp_t e;
        if (rst) begin
            sb_q.delete();
        end else begin
            if (bus0.o_valid || bus1.o_valid) begin
                if (sb_q.size() == 0) begin
                    chk("stray_beat", {30'b0, bus1.o_valid, bus0.o_valid}, 32'd0);
                end else begin
                    e = sb_q[0];
                    chk("valid0", bus0.o_valid, 1'b1);
                    chk("valid1", bus1.o_valid, 1'b1);
                    chk("C0", bus0.o_C, e.c);
                    chk("D0", bus0.o_D, e.d0);
                    chk("sat0", bus0.o_sat, e.s0);
                    chk("C1", bus1.o_C, e.c);
                    chk("D1", bus1.o_D, e.d1);
                    chk("sat1", bus1.o_sat, e.s1);
                    if (!bus0.i_ready)
                        chk("stall_ordy", bus0.o_ready, 1'b0);
                    if (bus0.i_ready) begin
                        void'(sb_q.pop_front());
                        out_cnt++;
                        last_out_cyc = cyc;
                    end
                end
            end
            if (bus0.i_valid && bus0.o_ready)
                sb_q.push_back(model(bus0.i_A, bus0.i_B, bus0.i_twiddle));
        end
    end

    task automatic drive_beat(input logic [31:0] a, b, w);
        int guard;
        bus0.i_valid   = 1'b1;
        bus0.i_A       = a;
        bus0.i_B       = b;
        bus0.i_twiddle = w;
        guard = 0;
        @(negedge clk);
        while (!bus0.o_ready && guard < 100) begin
            @(negedge clk);
            guard++;
        end
        chk("accept", bus0.o_ready, 1'b1);
        @(posedge clk);
        #1;
    endtask

    task automatic wait_out(output int n);
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!bus0.o_valid && n < 20);
    endtask

    task automatic wait_drain();
        int g;
        g = 0;
        while (sb_q.size() != 0 && g < 500) begin
            @(negedge clk);
            g++;
        end
        chk("drain", sb_q.size(), 32'd0);
        @(posedge clk);
        #1;
    endtask

    task automatic one_shot(input logic [31:0] a, b, w, output int lat);
        drive_beat(a, b, w);
        bus0.i_valid = 1'b0;
        wait_out(lat);
    endtask

    initial begin
        int lat, start, mark;
        bus0.i_valid   = 1'b0;
        bus0.i_A       = '0;
        bus0.i_B       = '0;
        bus0.i_twiddle = '0;

        #12;
        chk("rst_valid", bus0.o_valid, 1'b0);
        chk("rst_C", bus0.o_C, 32'd0);
        chk("rst_D", bus0.o_D, 32'd0);
        chk("rst_sat", bus0.o_sat, 1'b0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        @(posedge clk);
        #1;
        chk("rdy_after_rst", bus0.o_ready, 1'b1);

        one_shot(32'h4000_0000, 32'h2000_0000, 32'h7FFF_0000, lat);
        chk("basic_lat", lat, 32'd3);
        chk("basic_C", bus0.o_C, 32'h3000_0000);
        chk("basic_D", bus0.o_D, 32'h1000_0000);
        chk("basic_sat", bus0.o_sat, 1'b0);
        @(posedge clk);
        #1;

        one_shot(32'h7FFF_7FFF, 32'h8000_8000, 32'h8000_8000, lat);
        chk("sat_C", bus0.o_C, 32'h0000_0000);
        chk("sat_D", bus0.o_D, 32'h0000_8000);
        chk("sat_flag", bus0.o_sat, 1'b1);
        @(posedge clk);
        #1;

        one_shot(32'h2000_0000, 32'h0000_0000, 32'h0000_7FFF, lat);
        chk("conj_C", bus1.o_C, 32'h1000_0000);
        chk("conj_D", bus1.o_D, 32'h0000_F000);
        chk("noconj_D", bus0.o_D, 32'h0000_1000);
        @(posedge clk);
        #1;

        // Back-to-back: 100 beats, 3-cycle fill, no bubbles.
        rdy_mode = 0;
        mark  = out_cnt;
        start = cyc;
        for (int i = 0; i < 100; i++) drive_beat(rnd32(), rnd32(), rnd32());
        bus0.i_valid = 1'b0;
        wait_drain();
        chk("b2b_count", out_cnt - mark, 32'd100);
        chk("b2b_cycles", last_out_cyc - start + 1, 32'd103);

        // Random backpressure with random input bubbles.
        rdy_mode = 1;
        mark = out_cnt;
        for (int i = 0; i < 16; i++) begin
            if ($urandom_range(0, 3) == 0) begin
                bus0.i_valid = 1'b0;
                @(posedge clk);
                #1;
            end
            drive_beat(rnd32(), rnd32(), rnd32());
        end
        bus0.i_valid = 1'b0;
        wait_drain();
        chk("bp_count", out_cnt - mark, 32'd16);

        mark = out_cnt;
        for (int i = 0; i < 150; i++) drive_beat(rnd32(), rnd32(), rnd32());
        bus0.i_valid = 1'b0;
        wait_drain();
        chk("bp_long_count", out_cnt - mark, 32'd150);

        // Hard stall: pipe fills with three beats then refuses input.
        rdy_mode = 2;
        @(posedge clk);
        #1;
        for (int i = 0; i < 3; i++) drive_beat(rnd32(), rnd32(), rnd32());
        bus0.i_valid = 1'b0;
        repeat (5) @(negedge clk);
        chk("full_ordy", bus0.o_ready, 1'b0);
        chk("full_valid", bus0.o_valid, 1'b1);
        rdy_mode = 0;
        wait_drain();

        // Reset with three beats in flight.
        for (int i = 0; i < 3; i++) drive_beat(rnd32(), rnd32(), rnd32());
        bus0.i_valid = 1'b0;
        rst = 1'b1;
        #1;
        chk("mid_rst_valid", bus0.o_valid, 1'b0);
        chk("mid_rst_C", bus0.o_C, 32'd0);
        chk("mid_rst_D", bus0.o_D, 32'd0);
        chk("mid_rst_sat", bus0.o_sat, 1'b0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        @(posedge clk);
        #1;
        chk("mid_rst_ordy", bus0.o_ready, 1'b1);
        mark = out_cnt;
        one_shot(32'h1234_5678, 32'h0F0F_F0F0, 32'h5A82_A57E, lat);
        chk("post_rst_lat", lat, 32'd3);
        repeat (10) @(negedge clk);
        chk("post_rst_count", out_cnt - mark, 32'd1);

        $display("%0d/%0d checks passed", n_chk - n_fail, n_chk);
        $finish;
    end

endmodule
